// File: rtl/dvp_pkg.sv
// Shared types and constants for the DVP transmit source.
// Holds the frame FSM encoding, colour-bar palette and byte order.
package dvp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBACK,
    ST_ACTIVE,
    ST_VFRONT
  } dvp_state_e;

  localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
  localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
  localparam logic [15:0] BAR_CYAN    = 16'h07FF;
  localparam logic [15:0] BAR_GREEN   = 16'h07E0;
  localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
  localparam logic [15:0] BAR_RED     = 16'hF800;
  localparam logic [15:0] BAR_BLUE    = 16'h001F;
  localparam logic [15:0] BAR_BLACK   = 16'h0000;

  localparam bit HIGH_BYTE_FIRST = 1'b1;

  function automatic logic [15:0] bar_colour(
    input logic [2:0] idx
  );
    logic [15:0] c;
    unique case (idx)
      3'd0: c = BAR_WHITE;
      3'd1: c = BAR_YELLOW;
      3'd2: c = BAR_CYAN;
      3'd3: c = BAR_GREEN;
      3'd4: c = BAR_MAGENTA;
      3'd5: c = BAR_RED;
      3'd6: c = BAR_BLUE;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/dvp_tx_timing.sv
// Pixel-clock phase, beat/line counters and frame FSM.
// The *_nxt outputs are the values that take effect at the next update edge.
module dvp_tx_timing
  import dvp_pkg::*;
#(
  parameter int H_ACTIVE    = 640,
  parameter int H_BLANK     = 144,
  parameter int V_ACTIVE    = 480,
  parameter int VSYNC_LINES = 4,
  parameter int V_BACK      = 16,
  parameter int V_FRONT     = 8,
  localparam int LINE_BEATS = 2*H_ACTIVE + H_BLANK,
  localparam int BW         = $clog2(LINE_BEATS)
) (
  input  logic          clk_i,
  input  logic          resetn_i,
  input  logic          enable_i,
  output logic          pclk_o,
  output logic          upd_o,
  output dvp_state_e    state_nxt_o,
  output logic [BW-1:0] beat_nxt_o
);

  localparam int FRAME_LINES =
    VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT;
  localparam int LW = $clog2(FRAME_LINES);

  localparam logic [BW-1:0] BEAT_LAST =
    BW'(LINE_BEATS - 1);
  localparam logic [LW-1:0] LINE_LAST =
    LW'(FRAME_LINES - 1);
  localparam logic [LW-1:0] L_VBACK =
    LW'(VSYNC_LINES);
  localparam logic [LW-1:0] L_ACT =
    LW'(VSYNC_LINES + V_BACK);
  localparam logic [LW-1:0] L_VFRONT =
    LW'(VSYNC_LINES + V_BACK + V_ACTIVE);

  logic          phase_q;
  dvp_state_e    state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [LW-1:0] line_q, line_d;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    line_d  = line_q;
    if (state_q == ST_IDLE) begin
      beat_d = '0;
      line_d = '0;
      if (enable_i) state_d = ST_VSYNC;
    end else if (beat_q != BEAT_LAST) begin
      beat_d = beat_q + 1'b1;
    end else begin
      beat_d = '0;
      if (line_q == LINE_LAST) begin
        line_d  = '0;
        state_d = enable_i ? ST_VSYNC : ST_IDLE;
      end else begin
        line_d = line_q + 1'b1;
        unique case (1'b1)
          (line_d == L_VBACK):  state_d = ST_VBACK;
          (line_d == L_ACT):    state_d = ST_ACTIVE;
          (line_d == L_VFRONT): state_d = ST_VFRONT;
          default:              state_d = state_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      phase_q <= 1'b0;
      state_q <= ST_IDLE;
      beat_q  <= '0;
      line_q  <= '0;
    end else begin
      phase_q <= ~phase_q;
      if (phase_q) begin
        state_q <= state_d;
        beat_q  <= beat_d;
        line_q  <= line_d;
      end
    end
  end

  assign pclk_o      = phase_q;
  assign upd_o       = phase_q;
  assign state_nxt_o = state_d;
  assign beat_nxt_o  = beat_d;

endmodule

// File: rtl/dvp_tx_source.sv
// DVP camera-bus generator: stream or colour-bar pixels,
// serialised as RGB565 half-pixels on a clk/2 pixel clock.
module dvp_tx_source
  import dvp_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int PIXEL_WIDTH = 16,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int H_BLANK     = 144,
  parameter int VSYNC_LINES = 4,
  parameter int V_BACK      = 16,
  parameter int V_FRONT     = 8
) (
  input  logic                   clk_i,
  input  logic                   resetn_i,
  input  logic                   enable_i,
  input  logic                   pattern_en_i,
  input  logic [PIXEL_WIDTH-1:0] pixel_data_i,
  input  logic                   pixel_valid_i,
  output logic                   pixel_ready_o,
  output logic                   cam_pclk_o,
  output logic                   cam_vsync_o,
  output logic                   cam_href_o,
  output logic [DATA_WIDTH-1:0]  cam_half_pixel_o,
  output logic                   frame_start_o,
  output logic                   underflow_o
);

  localparam int BW = $clog2(2*H_ACTIVE + H_BLANK);
  localparam logic [BW-1:0] ACT_BEATS = BW'(2*H_ACTIVE);
  localparam int BAR_W = H_ACTIVE / 8;
  localparam int CW = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam logic [CW-1:0] BAR_LAST = CW'(BAR_W - 1);

  logic          upd;
  dvp_state_e    state_nxt;
  logic [BW-1:0] beat_nxt;
  logic          act_nxt, even_nxt;

  logic                   ready_q, vsync_q, href_q;
  logic                   fs_q, uf_q, pattern_q;
  logic [DATA_WIDTH-1:0]  half_q;
  logic [PIXEL_WIDTH-1:0] pix_q, pix_d;
  logic [CW-1:0]          bar_cnt_q;
  logic [2:0]             bar_idx_q;
  logic [DATA_WIDTH-1:0]  first_b, second_b;

  dvp_tx_timing #(
    .H_ACTIVE    (H_ACTIVE),
    .H_BLANK     (H_BLANK),
    .V_ACTIVE    (V_ACTIVE),
    .VSYNC_LINES (VSYNC_LINES),
    .V_BACK      (V_BACK),
    .V_FRONT     (V_FRONT)
  ) u_timing (
    .clk_i       (clk_i),
    .resetn_i    (resetn_i),
    .enable_i    (enable_i),
    .pclk_o      (cam_pclk_o),
    .upd_o       (upd),
    .state_nxt_o (state_nxt),
    .beat_nxt_o  (beat_nxt)
  );

  assign act_nxt  = (state_nxt == ST_ACTIVE) &&
                    (beat_nxt < ACT_BEATS);
  assign even_nxt = act_nxt && !beat_nxt[0];

  always_comb begin
    pix_d = '0;
    if (pattern_q)
      pix_d = PIXEL_WIDTH'(bar_colour(bar_idx_q));
    else if (pixel_valid_i)
      pix_d = pixel_data_i;
  end

  assign first_b  = HIGH_BYTE_FIRST ?
                    pix_d[PIXEL_WIDTH-1 -: DATA_WIDTH] :
                    pix_d[DATA_WIDTH-1:0];
  assign second_b = HIGH_BYTE_FIRST ?
                    pix_q[DATA_WIDTH-1:0] :
                    pix_q[PIXEL_WIDTH-1 -: DATA_WIDTH];

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      ready_q   <= 1'b0;
      vsync_q   <= 1'b0;
      href_q    <= 1'b0;
      fs_q      <= 1'b0;
      uf_q      <= 1'b0;
      pattern_q <= 1'b0;
      half_q    <= '0;
      pix_q     <= '0;
      bar_cnt_q <= '0;
      bar_idx_q <= '0;
    end else begin
      // counters are frozen between update edges, so the
      // upcoming beat is already known one cycle early
      ready_q <= !upd && even_nxt && !pattern_q;
      fs_q    <= 1'b0;
      if (upd) begin
        vsync_q <= (state_nxt == ST_VSYNC);
        href_q  <= act_nxt;
        if (state_nxt == ST_VSYNC && !vsync_q) begin
          fs_q      <= 1'b1;
          pattern_q <= pattern_en_i;
        end
        if (!act_nxt) begin
          half_q    <= '0;
          bar_cnt_q <= '0;
          bar_idx_q <= '0;
        end else if (even_nxt) begin
          pix_q  <= pix_d;
          half_q <= first_b;
          if (!pattern_q && !pixel_valid_i)
            uf_q <= 1'b1;
          if (bar_cnt_q == BAR_LAST) begin
            bar_cnt_q <= '0;
            bar_idx_q <= bar_idx_q + 3'd1;
          end else begin
            bar_cnt_q <= bar_cnt_q + 1'b1;
          end
        end else begin
          half_q <= second_b;
        end
      end
    end
  end

  assign pixel_ready_o    = ready_q;
  assign cam_vsync_o      = vsync_q;
  assign cam_href_o       = href_q;
  assign cam_half_pixel_o = half_q;
  assign frame_start_o    = fs_q;
  assign underflow_o      = uf_q;

endmodule

// File: tb/tb_dvp_tx_source.sv
// Directed bench for dvp_tx_source with small frame geometry
// (line = 40 clk, frame = 200 clk).
module tb_dvp_tx_source;

  localparam int HA = 8;
  localparam int HB = 4;
  localparam int VA = 2;
  localparam int VS = 1;
  localparam int VB = 1;
  localparam int VF = 1;
  localparam int NL = 2048;

  logic        clk = 1'b0;
  logic        resetn_i;
  logic        enable_i;
  logic        pattern_en_i;
  logic [15:0] pixel_data_i;
  logic        pixel_valid_i;
  logic        pixel_ready_o;
  logic        cam_pclk_o;
  logic        cam_vsync_o;
  logic        cam_href_o;
  logic [7:0]  cam_half_pixel_o;
  logic        frame_start_o;
  logic        underflow_o;

  always #5 clk = ~clk;

  dvp_tx_source #(
    .DATA_WIDTH  (8),
    .PIXEL_WIDTH (16),
    .H_ACTIVE    (HA),
    .V_ACTIVE    (VA),
    .H_BLANK     (HB),
    .VSYNC_LINES (VS),
    .V_BACK      (VB),
    .V_FRONT     (VF)
  ) dut (
    .clk_i            (clk),
    .resetn_i         (resetn_i),
    .enable_i         (enable_i),
    .pattern_en_i     (pattern_en_i),
    .pixel_data_i     (pixel_data_i),
    .pixel_valid_i    (pixel_valid_i),
    .pixel_ready_o    (pixel_ready_o),
    .cam_pclk_o       (cam_pclk_o),
    .cam_vsync_o      (cam_vsync_o),
    .cam_href_o       (cam_href_o),
    .cam_half_pixel_o (cam_half_pixel_o),
    .frame_start_o    (frame_start_o),
    .underflow_o      (underflow_o)
  );

  logic [15:0] bars [8] = '{
    16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
    16'hF81F, 16'hF800, 16'h001F, 16'h0000
  };

  int passed = 0;
  int total  = 0;

  logic       lv [NL];
  logic       lh [NL];
  logic       lf [NL];
  logic       lr [NL];
  logic       lu [NL];
  logic [7:0] ld [NL];
  int         n = 0;

  bit         drv_stream = 0;
  bit         rdy_prev = 0;
  bit         have_prev = 0;
  int         pix_idx = 0;
  int         drop_at = -1;
  int         viol = 0;
  logic [9:0] prev_o;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
  endtask

  task automatic step();
    logic [9:0] cur;
    @(negedge clk);
    cur = {cam_vsync_o, cam_href_o, cam_half_pixel_o};
    if (cam_pclk_o && have_prev && cur !== prev_o)
      viol++;
    prev_o    = cur;
    have_prev = 1;
    if (n < NL) begin
      lv[n] = cam_vsync_o;
      lh[n] = cam_href_o;
      lf[n] = frame_start_o;
      lr[n] = pixel_ready_o;
      lu[n] = underflow_o;
      ld[n] = cam_half_pixel_o;
    end
    n++;
    if (drv_stream && rdy_prev) pix_idx++;
    rdy_prev      = pixel_ready_o;
    pixel_data_i  = 16'h0100 + 16'(pix_idx);
    pixel_valid_i = drv_stream && (pix_idx != drop_at);
  endtask

  task automatic wait_vsync(input int maxc,
                            output bit ok,
                            output int k);
    ok = 0;
    k  = 0;
    while (!ok && k < maxc) begin
      step();
      k++;
      ok = (lv[n-1] === 1'b1);
    end
  endtask

  initial begin
    bit          ok;
    int          k, f1, f2, f3, f4, c0, c1, c2, c3;
    logic [15:0] b;
    logic [7:0]  e;

    resetn_i      = 0;
    enable_i      = 0;
    pattern_en_i  = 1;
    pixel_valid_i = 0;
    pixel_data_i  = 0;
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        32'({cam_pclk_o, cam_vsync_o, cam_href_o,
             cam_half_pixel_o, frame_start_o,
             pixel_ready_o, underflow_o}), 0);

    // frame 1: colour bars
    resetn_i = 1;
    enable_i = 1;
    wait_vsync(4, ok, k);
    chk("start_found", 32'(ok), 1);
    chk("start_within_2clk", 32'(k <= 2), 1);
    f1 = n - 1;
    chk("f1_frame_start", 32'(lf[f1]), 1);
    while (n < f1 + 100) step();
    pattern_en_i = 0;
    drv_stream   = 1;
    while (n < f1 + 201) step();

    c0 = 0; c1 = 0; c2 = 0; c3 = 0;
    for (int i = f1; i < f1 + 200; i++) begin
      c0 += int'(lv[i]);
      c1 += int'(lf[i]);
      c2 += int'(lh[i]);
      c3 += int'(lr[i]);
    end
    chk("f1_vsync_len", 32'(c0), 40);
    chk("f1_vsync_end", 32'({lv[f1+39], lv[f1+40]}), 2);
    chk("f1_fs_pulses", 32'(c1), 1);
    chk("f1_href_total", 32'(c2), 64);
    chk("f1_ready_count", 32'(c3), 0);
    chk("f1_href_edges",
        32'({lh[f1+79], lh[f1+80], lh[f1+111],
             lh[f1+112], lh[f1+120], lh[f1+151],
             lh[f1+152]}), 32'b0110110);
    c0 = 0;
    for (int i = f1; i < f1 + 200; i++)
      if (!lh[i] && ld[i] != 8'h00) c0++;
    chk("f1_data_zero_blank", 32'(c0), 0);
    for (int i = 0; i < 16; i++) begin
      b = bars[i/2];
      e = (i % 2 == 0) ? b[15:8] : b[7:0];
      chk("f1_bar_byte_a", 32'(ld[f1+80+2*i]), 32'(e));
      chk("f1_bar_byte_b", 32'(ld[f1+81+2*i]), 32'(e));
    end
    chk("f1_period", 32'({lv[f1+199], lv[f1+200],
                          lf[f1+200]}), 32'b011);

    // frame 2: stream, valid always high
    f2 = f1 + 200;
    while (n < f2 + 201) step();
    c0 = 0; c1 = 0;
    for (int i = f2; i < f2 + 200; i++)
      c0 += int'(lr[i]);
    for (int i = 0; i < 8; i++)
      c1 += int'(lr[f2+79+4*i]);
    chk("f2_ready_count", 32'(c0), 16);
    chk("f2_ready_spacing", 32'(c1), 8);
    chk("f2_ready_width", 32'({lr[f2+78], lr[f2+80]}), 0);
    for (int i = 0; i < 8; i++) begin
      chk("f2_hi_byte", 32'(ld[f2+80+4*i]), 32'h01);
      chk("f2_lo_byte", 32'(ld[f2+82+4*i]), 32'(i));
    end
    chk("f2_line1_px0",
        32'({ld[f2+120], ld[f2+122]}), 32'h0108);
    chk("f2_no_underflow", 32'(lu[f2+199]), 0);

    // frame 3: 3rd pixel missing, enable dropped mid-active
    f3 = f2 + 200;
    drop_at = 18;
    while (n < f3 + 100) step();
    enable_i = 0;
    while (n < f3 + 260) step();
    chk("f3_px0", 32'({ld[f3+80], ld[f3+82]}), 32'h0110);
    chk("f3_px1", 32'({ld[f3+84], ld[f3+86]}), 32'h0111);
    chk("f3_px2_zero",
        32'({ld[f3+88], ld[f3+89], ld[f3+90],
             ld[f3+91]}), 0);
    chk("f3_px3", 32'({ld[f3+92], ld[f3+94]}), 32'h0113);
    chk("f3_underflow_set",
        32'({lu[f3+87], lu[f3+88]}), 32'b01);
    chk("f3_underflow_sticky", 32'(lu[f3+259]), 1);
    chk("f3_ready_timing",
        32'({lr[f3+87], lr[f3+91]}), 32'b11);
    c0 = 0;
    for (int i = f3 + 80; i < f3 + 120; i++)
      c0 += int'(lh[i]);
    chk("f3_href_len", 32'(c0), 32);
    chk("f3_completes",
        32'({lh[f3+120], lh[f3+151], lv[f3+199]}),
        32'b110);
    c0 = 0; c1 = 0;
    for (int i = f3 + 200; i < f3 + 260; i++) begin
      c0 += int'(lf[i]);
      if (lv[i] || lh[i] || ld[i] != 8'h00) c1++;
    end
    chk("idle_no_fs", 32'(c0), 0);
    chk("idle_outputs_zero", 32'(c1), 0);

    // frame 4: async reset mid-line, then restart
    drv_stream   = 0;
    pattern_en_i = 1;
    enable_i     = 1;
    wait_vsync(4, ok, k);
    chk("f4_start_found", 32'(ok), 1);
    f4 = n - 1;
    while (n < f4 + 90) step();
    chk("f4_mid_line", 32'(lh[f4+89]), 1);
    #2;
    resetn_i  = 0;
    have_prev = 0;
    rdy_prev  = 0;
    #1;
    chk("async_reset_outputs",
        32'({cam_pclk_o, cam_vsync_o, cam_href_o,
             cam_half_pixel_o, frame_start_o,
             pixel_ready_o, underflow_o}), 0);
    repeat (2) @(negedge clk);
    chk("held_reset_outputs",
        32'({cam_pclk_o, cam_vsync_o, cam_href_o,
             cam_half_pixel_o, underflow_o}), 0);
    resetn_i = 1;
    wait_vsync(4, ok, k);
    chk("restart_found", 32'(ok), 1);
    chk("restart_within_2clk", 32'(k <= 2), 1);
    chk("restart_fs", 32'(lf[n-1]), 1);
    repeat (20) step();

    chk("pclk_stable_outputs", 32'(viol), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
